// File: rtl/cpu_bus_responder.sv
// CPU memory bus slave: address decode for work RAM, PPU registers and cartridge, plus the OAM DMA engine.
// Optional open-bus latch enabled by defining CPU_BUS_OPEN_BUS_EN.
module cpu_bus_responder #(
  parameter int DMA_LEN   = 256,
  parameter int ODD_ALIGN = 1,
  parameter int RAM_AW    = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       cpu_addr,
  input  logic              cpu_read,
  input  logic              cpu_write_n,
  input  logic [7:0]        cpu_wdata,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_stall,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata,
  output logic              ppu_cs,
  output logic [2:0]        ppu_reg,
  output logic              ppu_we,
  output logic [7:0]        ppu_wdata,
  input  logic [7:0]        ppu_rdata,
  output logic              cart_cs,
  output logic              cart_we,
  output logic [15:0]       cart_addr,
  output logic [7:0]        cart_wdata,
  input  logic [7:0]        cart_rdata
);

  localparam int IDX_W = (DMA_LEN > 256) ? $clog2(DMA_LEN) : 8;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DMA_LEN - 1);

  typedef enum logic [1:0] {IDLE, ALIGN, RD, WR} dma_state_t;
  typedef enum logic [2:0] {RGN_NONE, RGN_RAM, RGN_PPU, RGN_IO, RGN_CART} region_t;

  dma_state_t       state_reg, state_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic [7:0]       page_reg, page_next;
  logic             align_extra_reg, align_extra_next;
  logic             parity_reg;
  region_t          tag_reg;

  logic [15:0] src_addr;
  logic        src_read;
  logic        src_write;
  logic        src_access;
  logic [7:0]  src_wdata;
  logic        dma_wr;
  logic        dma_start;
  region_t     src_region;
  logic [7:0]  io_rdata;
  logic [7:0]  rdata_mux;

  function automatic region_t decode(input logic [15:0] a);
    if (a[15:13] == 3'b000)
      return RGN_RAM;
    else if (a[15:13] == 3'b001)
      return RGN_PPU;
    else if (a[15:5] == 11'h200)
      return RGN_IO;
    else
      return RGN_CART;
  endfunction

  assign cpu_stall = (state_reg != IDLE);

  // While stalled the DMA engine owns the bus and CPU strobes are dropped.
  always_comb begin
    src_addr  = cpu_addr;
    src_read  = 1'b0;
    src_write = 1'b0;
    src_wdata = cpu_wdata;
    dma_wr    = 1'b0;
    if (!cpu_stall) begin
      src_write = !cpu_write_n;
      src_read  = cpu_read && cpu_write_n;
    end else begin
      case (state_reg)
        RD: begin
          src_addr = {page_reg, idx_reg[7:0]};
          src_read = 1'b1;
        end
        WR:      dma_wr = 1'b1;
        default: ;
      endcase
    end
  end

  assign src_access = src_read || src_write;
  assign src_region = decode(src_addr);
  assign dma_start  = src_write && (cpu_addr == 16'h4014);

  always_comb begin
    rdata_mux = 8'h00;
    case (tag_reg)
      RGN_RAM:  rdata_mux = ram_rdata;
      RGN_PPU:  rdata_mux = ppu_rdata;
      RGN_IO:   rdata_mux = io_rdata;
      RGN_CART: rdata_mux = cart_rdata;
      default:  rdata_mux = 8'h00;
    endcase
  end

  assign cpu_rdata = rdata_mux;

  assign ram_addr   = src_addr[RAM_AW-1:0];
  assign ram_we     = src_write && (src_region == RGN_RAM);
  assign ram_wdata  = src_wdata;

  assign ppu_cs     = dma_wr || (src_access && (src_region == RGN_PPU));
  assign ppu_we     = dma_wr || (src_write && (src_region == RGN_PPU));
  assign ppu_reg    = dma_wr ? 3'd4 : src_addr[2:0];
  assign ppu_wdata  = dma_wr ? rdata_mux : src_wdata;

  assign cart_cs    = src_access && (src_region == RGN_CART);
  assign cart_we    = src_write && (src_region == RGN_CART);
  assign cart_addr  = src_addr;
  assign cart_wdata = src_wdata;

  always_comb begin
    state_next       = state_reg;
    idx_next         = idx_reg;
    page_next        = page_reg;
    align_extra_next = align_extra_reg;
    case (state_reg)
      IDLE: begin
        if (dma_start) begin
          state_next       = ALIGN;
          page_next        = cpu_wdata;
          idx_next         = '0;
          align_extra_next = (ODD_ALIGN != 0) && parity_reg;
        end
      end
      ALIGN: begin
        if (align_extra_reg)
          align_extra_next = 1'b0;
        else
          state_next = RD;
      end
      RD: state_next = WR;
      WR: begin
        if (idx_reg == IDX_LAST) begin
          idx_next   = '0;
          state_next = IDLE;
        end else begin
          idx_next   = idx_reg + 1'b1;
          state_next = RD;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      idx_reg         <= '0;
      page_reg        <= 8'h00;
      align_extra_reg <= 1'b0;
      parity_reg      <= 1'b0;
      tag_reg         <= RGN_NONE;
    end else begin
      state_reg       <= state_next;
      idx_reg         <= idx_next;
      page_reg        <= page_next;
      align_extra_reg <= align_extra_next;
      parity_reg      <= !parity_reg;
      if (src_read)
        tag_reg <= src_region;
    end
  end

`ifdef CPU_BUS_OPEN_BUS_EN
  logic [7:0] open_bus_reg;
  logic       rd_valid_reg;

  // Tracks the last byte seen on the data bus: CPU writes win over returned reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      open_bus_reg <= 8'h00;
      rd_valid_reg <= 1'b0;
    end else begin
      rd_valid_reg <= src_read;
      if (src_write)
        open_bus_reg <= cpu_wdata;
      else if (rd_valid_reg)
        open_bus_reg <= rdata_mux;
    end
  end

  assign io_rdata = open_bus_reg;
`else
  assign io_rdata = 8'h00;
`endif

endmodule

// File: tb/tb_cpu_bus_responder.sv
// Bench for cpu_bus_responder: slave models, directed decode cases, random traffic and OAM DMA runs.
module tb_cpu_bus_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] cpu_addr;
  logic        cpu_read;
  logic        cpu_write_n;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_stall;
  logic [10:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;
  logic        ppu_cs;
  logic [2:0]  ppu_reg;
  logic        ppu_we;
  logic [7:0]  ppu_wdata;
  logic [7:0]  ppu_rdata;
  logic        cart_cs;
  logic        cart_we;
  logic [15:0] cart_addr;
  logic [7:0]  cart_wdata;
  logic [7:0]  cart_rdata;

  always #5 clk = ~clk;

  cpu_bus_responder dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_addr(cpu_addr), .cpu_read(cpu_read), .cpu_write_n(cpu_write_n),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .ppu_cs(ppu_cs), .ppu_reg(ppu_reg), .ppu_we(ppu_we), .ppu_wdata(ppu_wdata),
    .ppu_rdata(ppu_rdata),
    .cart_cs(cart_cs), .cart_we(cart_we), .cart_addr(cart_addr), .cart_wdata(cart_wdata),
    .cart_rdata(cart_rdata)
  );

  // Slave models: synchronous RAM, PPU and cartridge return address-derived data.
  logic [7:0] mem [0:2047];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata  <= mem[ram_addr];
    ppu_rdata  <= {5'h15, ppu_reg};
    cart_rdata <= cart_addr[15:8] ^ cart_addr[7:0];
  end

  int cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  int         stall_cnt, cart_seen, ram_we_seen, bad_reg, ppu_we_cnt;
  logic [7:0] dma_q [$];
  always @(negedge clk) begin
    if (cpu_stall) stall_cnt++;
    if (ppu_cs && ppu_we) begin
      ppu_we_cnt++;
      if (cpu_stall) begin
        dma_q.push_back(ppu_wdata);
        if (ppu_reg != 3'd4) bad_reg++;
      end
    end
    if (cpu_stall && cart_cs) cart_seen++;
    if (cpu_stall && ram_we)  ram_we_seen++;
  end

  int         checks = 0;
  int         fails  = 0;
  logic [7:0] ref_ram [0:2047];
  logic [7:0] ob;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cpu_read    = 1'b0;
    cpu_write_n = 1'b1;
  endtask

  // 0 RAM, 1 PPU, 2 IO, 3 CART
  function automatic int region(input logic [15:0] a);
    if (a < 16'h2000)      return 0;
    else if (a < 16'h4000) return 1;
    else if (a < 16'h4020) return 2;
    else                   return 3;
  endfunction

  function automatic logic [7:0] expected_read(input logic [15:0] a);
    logic [7:0] hi, lo;
    hi = a[15:8];
    lo = a[7:0];
    case (region(a))
      0: return ref_ram[a % 2048];
      1: return 8'hA8 + 8'(a % 8);
`ifdef CPU_BUS_OPEN_BUS_EN
      2: return ob;
`else
      2: return 8'h00;
`endif
      default: return hi ^ lo;
    endcase
  endfunction

  task automatic do_access(input bit rd, input bit wr, input logic [15:0] a, input logic [7:0] d);
    int         rg;
    logic [7:0] expv;
    logic [4:0] exp_sel;
    rg          = region(a);
    cpu_addr    = a;
    cpu_read    = rd;
    cpu_write_n = !wr;
    cpu_wdata   = d;
    #1;
    exp_sel = {wr && rg == 0, (rd || wr) && rg == 1, wr && rg == 1,
               (rd || wr) && rg == 3, wr && rg == 3};
    chk("selects", {27'd0, ram_we, ppu_cs, ppu_we, cart_cs, cart_we}, {27'd0, exp_sel});
    if (rg == 0) chk("ram_addr", {21'd0, ram_addr}, a % 2048);
    if (rg == 1) chk("ppu_reg", {29'd0, ppu_reg}, a % 8);
    if (rg == 3) chk("cart_addr", {16'd0, cart_addr}, {16'd0, a});
    expv = expected_read(a);
    $display("access rd=%0d wr=%0d addr=%04h wdata=%02h", rd, wr, a, d);
    tick();
    idle();
    if (wr) begin
      ob = d;
      if (rg == 0) ref_ram[a % 2048] = d;
    end else if (rd) begin
      #1;
      chk("rdata", {24'd0, cpu_rdata}, {24'd0, expv});
      ob = expv;
    end
    tick();
  endtask

  task automatic start_dma(input logic [7:0] page, input int par);
    if (cyc % 2 != par) tick();
    stall_cnt   = 0;
    cart_seen   = 0;
    ram_we_seen = 0;
    bad_reg     = 0;
    dma_q.delete();
    cpu_addr    = 16'h4014;
    cpu_wdata   = page;
    cpu_write_n = 1'b0;
    cpu_read    = 1'b0;
    #1;
    chk("dma_start_no_slave", {29'd0, ram_we, ppu_cs, cart_cs}, 32'd0);
    $display("dma start page=%02h parity=%0d", page, par);
    tick();
    idle();
    chk("stall_after_start", {31'd0, cpu_stall}, 32'd1);
  endtask

  // Drives junk CPU strobes while stalled, then checks the whole transfer.
  task automatic finish_dma(input logic [7:0] page, input int par);
    int exp_stall;
    for (int n = 0; n < 700 && cpu_stall; n++) begin
      cpu_addr    = ($urandom_range(0, 3) == 0) ? 16'h4014 : 16'($urandom);
      cpu_read    = 1'($urandom);
      cpu_write_n = 1'($urandom);
      cpu_wdata   = 8'($urandom);
      tick();
    end
    idle();
    chk("dma_end", {31'd0, cpu_stall}, 32'd0);
    exp_stall = 1 + par + 2 * 256;
    chk("stall_cycles", stall_cnt, exp_stall);
    chk("dma_writes", dma_q.size(), 256);
    for (int i = 0; i < 256 && i < dma_q.size(); i++)
      chk("dma_byte", {24'd0, dma_q[i]}, {24'd0, ref_ram[(int'(page) * 256 + i) % 2048]});
    chk("dma_cart_cs", cart_seen, 0);
    chk("dma_ram_we", ram_we_seen, 0);
    chk("dma_ppu_reg", bad_reg, 0);
    ob = ref_ram[(int'(page) * 256 + 255) % 2048];
    $display("dma done page=%02h stall=%0d writes=%0d", page, stall_cnt, dma_q.size());
  endtask

  task automatic preload(input logic [7:0] page, input logic [7:0] key);
    for (int i = 0; i < 256; i++) begin
      mem[(int'(page) * 256 + i) % 2048]     = 8'(i) ^ key;
      ref_ram[(int'(page) * 256 + i) % 2048] = 8'(i) ^ key;
    end
  endtask

  initial begin
    int         rg, op, wcnt;
    logic [15:0] a;
    idle();
    cpu_addr  = 16'h0000;
    cpu_wdata = 8'h00;
    rst_n     = 1'b0;
    ob        = 8'h00;
    for (int i = 0; i < 2048; i++) begin
      mem[i]     = 8'($urandom);
      ref_ram[i] = mem[i];
    end
    repeat (3) @(posedge clk);
    #1;
    chk("reset_stall", {31'd0, cpu_stall}, 32'd0);
    chk("reset_rdata", {24'd0, cpu_rdata}, 32'd0);
    chk("reset_selects", {27'd0, ram_we, ppu_cs, ppu_we, cart_cs, cart_we}, 32'd0);
    rst_n = 1'b1;
    tick();

    do_access(0, 1, 16'h0805, 8'hA5);
    do_access(1, 0, 16'h0005, 8'h00);
    do_access(1, 0, 16'h3FFC, 8'h00);
    do_access(0, 1, 16'h3FF9, 8'h77);
    do_access(0, 1, 16'h4016, 8'h3C);
    do_access(1, 0, 16'h4015, 8'h00);
`ifdef CPU_BUS_OPEN_BUS_EN
    chk("open_bus_value", {24'd0, cpu_rdata}, 32'h3C);
`else
    chk("open_bus_value", {24'd0, cpu_rdata}, 32'h00);
`endif
    do_access(1, 1, 16'h0123, 8'h9E);
    do_access(1, 0, 16'h1923, 8'h00);

    for (int t = 0; t < 80; t++) begin
      rg = $urandom_range(0, 3);
      op = $urandom_range(0, 3);
      case (rg)
        0:       a = 16'($urandom_range(0, 16'h1FFF));
        1:       a = 16'($urandom_range(16'h2000, 16'h3FFF));
        2:       a = 16'($urandom_range(16'h4000, 16'h401F));
        default: a = 16'($urandom_range(16'h4020, 16'hFFFF));
      endcase
      if (op != 0 && a == 16'h4014) a = 16'h4016;
      do_access(op == 0 || op == 2, op == 1 || op == 2, a, 8'($urandom));
    end

    preload(8'h02, 8'h5A);
    start_dma(8'h02, 0);
    finish_dma(8'h02, 0);
    do_access(1, 0, 16'h4017, 8'h00);
    start_dma(8'h02, 1);
    finish_dma(8'h02, 1);

    start_dma(8'h02, 0);
    for (int n = 0; n < 400 && dma_q.size() < 100; n++) tick();
    chk("reached_byte_100", dma_q.size(), 100);
    rst_n = 1'b0;
    #1;
    chk("reset_mid_dma_stall", {31'd0, cpu_stall}, 32'd0);
    wcnt = ppu_we_cnt;
    ob   = 8'h00;
    repeat (3) tick();
    rst_n = 1'b1;
    chk("reset_mid_dma_rdata", {24'd0, cpu_rdata}, 32'd0);
    repeat (4) tick();
    chk("no_ppu_we_after_reset", ppu_we_cnt, wcnt);
    chk("idle_after_reset", {31'd0, cpu_stall}, 32'd0);

    preload(8'h03, 8'(($urandom_range(0, 255))));
    op = $urandom_range(0, 1);
    start_dma(8'h03, op);
    finish_dma(8'h03, op);
    do_access(1, 0, 16'h4014, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
